regbank_wb_ctrl: RTL
====================

# regbank_wb_ctrl

- Write-back controller in front of the 32×32 register bank.
- Shares the bank's single write port between `N_REQ` result producers: ALU, load unit and mul/div.
- Keeps a pending-write scoreboard so decode can stall on RAW and WAW hazards.
- Sits between the execute/memory units and the register bank. Decode queries it combinationally each cycle.

## Interface
Parameters:
- `N_REQ`, default 3: number of write-back requesters. Index 0 = ALU, 1 = load, 2 = mul/div.
- `XLEN`, default 32: data width.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst_n_i`, input, 1: reset, synchronous, active-low.
- `req_valid_i`, input, `N_REQ`: requester has a result.
- `req_rd_i`, input, `N_REQ`×5: destination register per requester.
- `req_data_i`, input, `N_REQ`×`XLEN`: result data per requester.
- `req_ready_o`, output, `N_REQ`: one-hot grant; result is consumed this cycle.
- `we_o`, input-side of bank, output, 1: register-bank write enable.
- `rd_addr_o`, output, 5: register-bank write address.
- `rd_data_o`, output, `XLEN`: register-bank write data.
- `issue_valid_i`, input, 1: decode wants to issue an instruction.
- `issue_has_rd_i`, input, 1: the issuing instruction writes a register.
- `issue_rd_i`, input, 5: destination register of the issuing instruction.
- `issue_ready_o`, output, 1: issue accepted this cycle.
- `rs1_addr_i`, `rs2_addr_i`, input, 5 each: source registers being decoded.
- `rs1_busy_o`, `rs2_busy_o`, output, 1 each: source has an outstanding write.
- `pending_cnt_o`, output, 6: number of set scoreboard bits.

## Operation
Write-port arbitration:
- Round-robin over asserted `req_valid_i`, starting at pointer `rr_q`.
- Exactly one grant per cycle when any request is valid.
- On a grant to index k, `rr_q` becomes (k+1) mod `N_REQ`. With no grant, `rr_q` holds.
- The granted request drives `rd_addr_o`/`rd_data_o`. `we_o` = grant and `rd != 0`.
- A request with `rd = 0` is still granted and consumed, but `we_o` stays 0.
- Requesters hold `valid`, `rd` and `data` stable until ready. A requester may not drop `valid` without a grant.

Scoreboard `pend_q[31:1]` (x0 is never pending):
- Commit: granted `rd != 0` clears `pend_q[rd]`.
- Issue: a fire is `issue_valid_i && issue_ready_o`. A fire with `issue_has_rd_i` and `issue_rd_i != 0` sets `pend_q[issue_rd_i]`.
- Same-cycle set and clear on the same index: set wins, because the new writer is now outstanding.
- `issue_ready_o` = `rst_n_i` AND NOT(`issue_has_rd_i` AND `issue_rd_i != 0` AND `pend_q[issue_rd_i]` AND NOT clear-this-cycle[`issue_rd_i`]). This stalls WAW.
- `rsX_busy_o` = `pend_q[rsX]` AND NOT (`we_o` AND `rd_addr_o == rsX`).
  - The bank's write-first bypass supplies that value in the same cycle.
  - x0 is never busy.
- `pending_cnt_o` = popcount(`pend_q`), registered and updated with `pend_q`.

Reset (`rst_n_i` low at a rising edge):
- `pend_q` cleared, `rr_q` = 0, `pending_cnt_o` = 0.
- While `rst_n_i` is low, `req_ready_o` = 0, `we_o` = 0 and `issue_ready_o` = 0.
- Reset mid-operation discards all outstanding pending bits. In-flight requesters are flushed by the same reset.

## Timing
- Grant, `req_ready_o` and the write-port outputs are combinational in the request cycle.
- The bank is written at the end of that cycle. Write latency is 0 cycles added.
- Scoreboard set and clear take effect at the same edge as the bank write.
- Busy drops combinationally in the commit cycle; no extra bubble.
- Worst-case wait for a continuously valid requester is `N_REQ`−1 cycles.
- `issue_ready_o` and `rsX_busy_o` depend combinationally on `pend_q` and the current grant. They have no path from `issue_valid_i`.

## Structure
- Package `regbank_pkg`:
  - `XLEN`, `REG_ADDR_W` = 5, `N_REGS` = 32.
  - Requester index constants `WB_ALU`, `WB_LSU`, `WB_MDU`.
- Sub-module `rr_arbiter`:
  - Parameterised on N.
  - Inputs: `req`, `ptr`. Outputs: one-hot `gnt`, `gnt_idx`.
  - Purely combinational.
- Pointer, scoreboard and counter live in `regbank_wb_ctrl`.

## Test plan
- Reset: hold `rst_n_i` = 0 for 2 cycles with all `req_valid_i` = 1 → `we_o` = 0, `req_ready_o` = 000, `pending_cnt_o` = 0.
- Round-robin: all three requesters valid continuously (`rd` = 5, 6, 7) → grants cycle 001, 010, 100, 001; `rd_addr_o` = 5, 6, 7, 5.
- RAW bypass:
  - Issue with `rd` = 3 → `pending_cnt_o` = 1, `rs1_busy_o` = 1 for `rs1` = 3.
  - In the cycle the load requester commits `rd` = 3 → `rs1_busy_o` = 0 and `we_o` = 1.
- WAW stall:
  - x4 pending; issue with `rd` = 4 → `issue_ready_o` = 0.
  - Same issue in the commit cycle of x4 → `issue_ready_o` = 1, and `pend_q[4]` stays 1.
- x0 handling:
  - Issue with `rd` = 0 → no scoreboard change.
  - Request with `rd` = 0 → granted, `we_o` = 0, `rs1_busy_o` for x0 always 0.
- Reset mid-operation: 5 registers pending, assert reset → `pending_cnt_o` = 0 and all busy outputs 0 on the next cycle.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared constants, types and helpers for the register-bank write-back slice.
package regbank_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned N_REGS     = 32;

  // Write-back requester indices into the arbiter.
  localparam int unsigned WB_ALU = 0;
  localparam int unsigned WB_LSU = 1;
  localparam int unsigned WB_MDU = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  function automatic logic [5:0] popcount_regs(input logic [N_REGS-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      c = c + {5'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N    = 3,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regbank_wb_ctrl.sv
// Write-back controller: arbitrates the register bank's single write port and
// keeps the pending-write scoreboard that decode uses for RAW/WAW stalls.
module regbank_wb_ctrl
  import regbank_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*5-1:0]      req_rd_i,
  input  logic [N_REQ*XLEN-1:0]   req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    we_o,
  output logic [4:0]              rd_addr_o,
  output logic [XLEN-1:0]         rd_data_o,
  input  logic                    issue_valid_i,
  input  logic                    issue_has_rd_i,
  input  logic [4:0]              issue_rd_i,
  output logic                    issue_ready_o,
  input  logic [4:0]              rs1_addr_i,
  input  logic [4:0]              rs2_addr_i,
  output logic                    rs1_busy_o,
  output logic                    rs2_busy_o,
  output logic [5:0]              pending_cnt_o
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  arb_req;
  logic [N_REQ-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic [IDX_W-1:0]  rr_q;
  logic              any_gnt;
  reg_addr_t         sel_rd;
  logic [XLEN-1:0]   sel_data;
  // Bit 0 is carried for simple indexing but is forced to zero: x0 is never pending.
  logic [N_REGS-1:0] pend_q, pend_d, clr_vec, set_vec;
  logic [5:0]        cnt_q;
  logic              issue_fire;

  assign arb_req = rst_n_i ? req_valid_i : '0;

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req     (arb_req),
    .ptr     (rr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign any_gnt     = |gnt;
  assign req_ready_o = gnt;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    if (any_gnt) begin
      sel_rd   = req_rd_i[32'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
      sel_data = req_data_i[32'(gnt_idx)*XLEN +: XLEN];
    end
  end

  assign we_o      = any_gnt && (sel_rd != '0);
  assign rd_addr_o = sel_rd;
  assign rd_data_o = sel_data;

  always_comb begin
    clr_vec = '0;
    if (we_o) clr_vec[rd_addr_o] = 1'b1;
  end

  // A WAW stall is lifted in the cycle the older writer commits.
  assign issue_ready_o = rst_n_i &&
                         !(issue_has_rd_i && (issue_rd_i != '0) &&
                           pend_q[issue_rd_i] && !clr_vec[issue_rd_i]);
  assign issue_fire    = issue_valid_i && issue_ready_o;

  // Set after clear so a same-cycle re-issue keeps the register outstanding.
  always_comb begin
    set_vec = '0;
    if (issue_fire && issue_has_rd_i && (issue_rd_i != '0)) set_vec[issue_rd_i] = 1'b1;
    pend_d    = (pend_q & ~clr_vec) | set_vec;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      pend_q <= '0;
      cnt_q  <= '0;
      rr_q   <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= popcount_regs(pend_d);
      if (any_gnt) begin
        rr_q <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  assign rs1_busy_o    = pend_q[rs1_addr_i] && !(we_o && (rd_addr_o == rs1_addr_i));
  assign rs2_busy_o    = pend_q[rs2_addr_i] && !(we_o && (rd_addr_o == rs2_addr_i));
  assign pending_cnt_o = cnt_q;

endmodule
